// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table extractor: FSM states, row count
// and the row-to-code-bit mapping (row 000 lands in code[7]).
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_t;

    localparam int TT_ROWS = 8;

    function automatic logic [2:0] tt_row_bit(input logic [2:0] row);
        return 3'd7 - row;
    endfunction

endpackage

// File: rtl/tt_phase_timer.sv
// Loadable down-counter that paces the SETTLE and SAMPLE phases; expire marks
// the final cycle of the currently loaded phase.
module tt_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps the 8 input rows of a 3-input device and assembles its 8-bit truth-table
// code. Defining TT_CHECK_EN adds an expected-code input and a registered match flag.
module truth_table_extractor
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CNT    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic [7:0] unstable
`ifdef TT_CHECK_EN
    ,
    input  logic [7:0] expected,
    output logic       match
`endif
);

    localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CNT) ? SETTLE_CYCLES : SAMPLE_CNT;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CNT - 1);
    localparam logic [2:0]    LAST_ROW    = 3'(TT_ROWS - 1);

    tt_state_t   state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  dut_in_q, dut_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  unstable_q, unstable_d;
    logic        first_q, first_d;
    logic        diff_q, diff_d;

    logic          timer_load;
    logic          timer_en;
    logic [TW-1:0] timer_val;
    logic [TW-1:0] timer_cnt;
    logic          timer_expire;

    logic first_now;
    logic sample_diff;

    tt_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .load_val(timer_val),
        .cnt     (timer_cnt),
        .expire  (timer_expire)
    );

    // The first sample cycle of a row is the one where the freshly loaded count is intact.
    assign first_now   = (timer_cnt == SAMPLE_LOAD);
    assign sample_diff = first_now ? 1'b0 : (diff_q | (dut_out ^ first_q));

`ifdef TT_CHECK_EN
    logic match_q, match_d;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        dut_in_d   = dut_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        code_d     = code_q;
        unstable_d = unstable_q;
        first_d    = first_q;
        diff_d     = diff_q;
        timer_load = 1'b0;
        timer_val  = SETTLE_LOAD;
        timer_en   = (state_q == SETTLE) || (state_q == SAMPLE);
`ifdef TT_CHECK_EN
        match_d    = match_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    row_d      = 3'd0;
                    dut_in_d   = 3'd0;
                    busy_d     = 1'b1;
                    code_d     = 8'h00;
                    unstable_d = 8'h00;
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LOAD;
`ifdef TT_CHECK_EN
                    match_d    = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    dut_in_d = 3'd0;
                end else if (timer_expire) begin
                    state_d    = SAMPLE;
                    timer_load = 1'b1;
                    timer_val  = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    dut_in_d = 3'd0;
                end else begin
                    first_d = first_now ? dut_out : first_q;
                    diff_d  = sample_diff;
                    if (timer_expire) begin
                        code_d[tt_row_bit(row_q)]     = dut_out;
                        unstable_d[tt_row_bit(row_q)] = sample_diff;
                        if (row_q == LAST_ROW) begin
                            state_d  = DONE;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            dut_in_d = 3'd0;
                        end else begin
                            state_d    = SETTLE;
                            row_d      = row_q + 3'd1;
                            dut_in_d   = row_q + 3'd1;
                            timer_load = 1'b1;
                            timer_val  = SETTLE_LOAD;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef TT_CHECK_EN
                match_d = (code_q == expected) && (unstable_q == 8'h00);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= 3'd0;
            dut_in_q   <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            code_q     <= 8'h00;
            unstable_q <= 8'h00;
            first_q    <= 1'b0;
            diff_q     <= 1'b0;
`ifdef TT_CHECK_EN
            match_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            code_q     <= code_d;
            unstable_q <= unstable_d;
            first_q    <= first_d;
            diff_q     <= diff_d;
`ifdef TT_CHECK_EN
            match_q    <= match_d;
`endif
        end
    end

    assign dut_in1  = dut_in_q[2];
    assign dut_in2  = dut_in_q[1];
    assign dut_in3  = dut_in_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign code     = code_q;
    assign unstable = unstable_q;
`ifdef TT_CHECK_EN
    assign match    = match_q;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: a modelled 3-input device with injectable sample
// glitches, a cycle-indexed reference model, and directed plus randomised sweeps.
module tb_truth_table_extractor;

    localparam int S        = 4;
    localparam int N        = 3;
    localparam int ROW_CYC  = S + N;
    localparam int BUSY_CYC = 8 * ROW_CYC;
    localparam int DONE_T   = BUSY_CYC + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic       dut_in1, dut_in2, dut_in3;
    logic       busy, done;
    logic [7:0] code, unstable;
`ifdef TT_CHECK_EN
    logic [7:0] expected;
    logic       match;
`endif

    always #5 clk = ~clk;

    truth_table_extractor #(
        .SETTLE_CYCLES(S),
        .SAMPLE_CNT   (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dut_out (dut_out),
        .dut_in1 (dut_in1),
        .dut_in2 (dut_in2),
        .dut_in3 (dut_in3),
        .busy    (busy),
        .done    (done),
        .code    (code),
        .unstable(unstable)
`ifdef TT_CHECK_EN
        ,
        .expected(expected),
        .match   (match)
`endif
    );

    // Device under characterisation: truth table plus per-row sample-glitch mask.
    logic [7:0]   dev_code;
    logic [N-1:0] glitch_mask [8];

    // Reference model: m_t counts cycles since the accepted start (0 = idle,
    // 1..BUSY_CYC = sweeping, DONE_T = done pulse).
    int         m_t;
    logic [7:0] m_code, m_unst;
    logic       m_match;
    logic       samp [8][N];

    int n_pass = 0;
    int n_chk  = 0;
    bit cmp_en = 1'b0;

    int         lat, bc;
    logic [7:0] exp_c, exp_u;

    function automatic int row_of(input int t);
        return (t - 1) / ROW_CYC;
    endfunction

    function automatic int phase_of(input int t);
        return (t - 1) % ROW_CYC;
    endfunction

    function automatic logic glitch_at(input int t);
        if (t < 1 || t > BUSY_CYC) return 1'b0;
        if (phase_of(t) < S) return 1'b0;
        return glitch_mask[row_of(t)][phase_of(t) - S];
    endfunction

    function automatic logic row_unstable(input int rw, input logic v);
        logic first;
        logic res;
        first = (N == 1) ? v : samp[rw][0];
        res   = (v != first);
        for (int i = 1; i < N - 1; i++) res = res | (samp[rw][i] != first);
        return res;
    endfunction

    assign dut_out = dev_code[3'd7 - {dut_in1, dut_in2, dut_in3}] ^ glitch_at(m_t);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t     <= 0;
            m_code  <= 8'h00;
            m_unst  <= 8'h00;
            m_match <= 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t     <= 1;
                m_code  <= 8'h00;
                m_unst  <= 8'h00;
                m_match <= 1'b0;
            end
        end else if (m_t == DONE_T) begin
            m_t <= 0;
`ifdef TT_CHECK_EN
            m_match <= (m_code == expected) && (m_unst == 8'h00);
`endif
        end else if (abort) begin
            m_t <= 0;
        end else begin
            if (phase_of(m_t) >= S) begin
                samp[row_of(m_t)][phase_of(m_t) - S] <= dut_out;
                if (phase_of(m_t) - S == N - 1) begin
                    m_code[7 - row_of(m_t)] <= dut_out;
                    m_unst[7 - row_of(m_t)] <= row_unstable(row_of(m_t), dut_out);
                end
            end
            m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_t >= 1 && m_t <= BUSY_CYC));
            chk("done", 32'(done), 32'(m_t == DONE_T));
            chk("dut_in", 32'({dut_in1, dut_in2, dut_in3}),
                (m_t >= 1 && m_t <= BUSY_CYC) ? 32'(row_of(m_t)) : 32'd0);
            chk("code", 32'(code), 32'(m_code));
            chk("unstable", 32'(unstable), 32'(m_unst));
`ifdef TT_CHECK_EN
            chk("match", 32'(match), 32'(m_match));
`endif
        end
    end

    task automatic sweep(input bit repulse, output int lat_o, output int bc_o);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat_o = 1;
        bc_o  = 0;
        while (!done && lat_o < DONE_T + 20) begin
            if (busy) bc_o++;
            start = repulse && (lat_o == 5 || lat_o == 30);
            @(negedge clk);
            lat_o++;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_and_wait(input int n);
        int t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1;
        while (t < n) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dev_code = 8'hDC;
        for (int r = 0; r < 8; r++) glitch_mask[r] = '0;
`ifdef TT_CHECK_EN
        expected = 8'hDC;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dut_in", 32'({dut_in1, dut_in2, dut_in3}), 32'd0);
        chk("reset_code", 32'(code), 32'd0);
        chk("reset_unstable", 32'(unstable), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // 0xDC device
        sweep(1'b0, lat, bc);
        chk("dc_latency", 32'(lat), 32'd57);
        chk("dc_busy_cycles", 32'(bc), 32'd56);
        chk("dc_code", 32'(code), 32'hDC);
        chk("dc_unstable", 32'(unstable), 32'h00);
`ifdef TT_CHECK_EN
        chk("dc_match", 32'(match), 32'd1);
`endif

        // Tied-0 then tied-1 device
        dev_code = 8'h00;
        sweep(1'b0, lat, bc);
        chk("tie0_code", 32'(code), 32'h00);
        chk("tie0_busy_cycles", 32'(bc), 32'd56);
        dev_code = 8'hFF;
        sweep(1'b0, lat, bc);
        chk("tie1_code", 32'(code), 32'hFF);
        chk("tie1_busy_cycles", 32'(bc), 32'd56);

        // Middle-sample glitch on row 010
        dev_code       = 8'hDC;
        glitch_mask[2] = 3'b010;
        sweep(1'b0, lat, bc);
        chk("glitch_unstable", 32'(unstable), 32'h20);
        chk("glitch_code5", 32'(code[5]), 32'd0);
        chk("glitch_code", 32'(code), 32'hDC);
        glitch_mask[2] = '0;

        // Abort during SETTLE of row 4, then a clean sweep
        start_and_wait(30);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dut_in", 32'({dut_in1, dut_in2, dut_in3}), 32'd0);
        chk("abort_partial_code", 32'(code), 32'hD0);
        repeat (4) @(negedge clk);
        sweep(1'b0, lat, bc);
        chk("post_abort_code", 32'(code), 32'hDC);
        chk("post_abort_latency", 32'(lat), 32'd57);

        // start re-pulsed mid-sweep is ignored
        sweep(1'b1, lat, bc);
        chk("repulse_latency", 32'(lat), 32'd57);
        chk("repulse_code", 32'(code), 32'hDC);

        // Asynchronous reset mid-sweep
        start_and_wait(20);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dut_in", 32'({dut_in1, dut_in2, dut_in3}), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_unstable", 32'(unstable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef TT_CHECK_EN
        expected = 8'hDD;
        sweep(1'b0, lat, bc);
        chk("dd_match", 32'(match), 32'd0);
`endif

        // Randomised devices and glitch patterns
        for (int it = 0; it < 8; it++) begin
            dev_code = 8'($urandom);
            for (int r = 0; r < 8; r++)
                glitch_mask[r] = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            exp_c = 8'h00;
            exp_u = 8'h00;
            for (int r = 0; r < 8; r++) begin
                exp_c[7 - r] = dev_code[7 - r] ^ glitch_mask[r][N - 1];
                exp_u[7 - r] = (glitch_mask[r] != '0) && (glitch_mask[r] != {N{1'b1}});
            end
`ifdef TT_CHECK_EN
            expected = exp_c;
`endif
            sweep(1'b0, lat, bc);
            chk("rand_code", 32'(code), 32'(exp_c));
            chk("rand_unstable", 32'(unstable), 32'(exp_u));
            chk("rand_latency", 32'(lat), 32'd57);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
